// File: rtl/mem_pkg.sv
// Shared types and the address legality rule for the byte-lane memory responder.
// The legality check is widened so that addresses near 2^32 cannot wrap into range.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

   typedef logic [7:0] byte_lane_t;

   localparam int LANES = 4;

   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
      logic [32:0] last_byte;
      last_byte = {1'b0, addr} + 33'd3;
      return (addr[1:0] == 2'b00) && (last_byte < {1'b0, mem_bytes});
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with one 4-lane synchronous write port and one 4-lane read port.
// Contents are deliberately left unreset so simulation can preload them.
module mem_byte_array
   import mem_pkg::*;
#(
   parameter  int MEM_BYTES = 4096,
   localparam int AW        = $clog2(MEM_BYTES)
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [AW-1:0]             addr,
   input  byte_lane_t [0:LANES-1]    wr_data,
   output byte_lane_t [0:LANES-1]    rd_data
);

   byte_lane_t mem [MEM_BYTES];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            mem[addr + AW'(i)] <= wr_data[i];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < LANES; i++) begin
         rd_data[i] = mem[addr + AW'(i)];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: latches a request in IDLE, counts down in BUSY,
// performs the access on the terminal count and pulses mem_ready in DONE.
//
//   state | meaning
//   IDLE  | waiting for mem_req; request registers load on acceptance
//   BUSY  | latency down-counter running; access happens on the edge it reads 0
//   DONE  | mem_ready/mem_err presented for one cycle, requests ignored
module mem_responder
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = 4096,
   parameter int LATENCY   = 4
) (
   input  logic                      clk,
   input  logic                      rst_b,
   input  logic                      mem_req,
   input  logic [31:0]               mem_addr,
   input  logic                      mem_write_en,
   input  byte_lane_t [0:LANES-1]    mem_data_in,
   output byte_lane_t [0:LANES-1]    mem_data_out,
   output logic                      mem_ready,
   output logic                      mem_busy,
   output logic                      mem_err
);

   localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int               AW       = $clog2(MEM_BYTES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   mem_state_t                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [31:0]                addr_q;
   logic                       we_q;
   byte_lane_t [0:LANES-1]     wdata_q;
   byte_lane_t [0:LANES-1]     rd_data;
   logic                       accept;
   logic                       access;
   logic                       legal;
   logic                       wr_en;

   assign legal = addr_ok(addr_q, 32'(MEM_BYTES));
   assign wr_en = access & we_q & legal;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req) begin
               accept  = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         mem_data_out <= '0;
         mem_ready    <= 1'b0;
         mem_busy     <= 1'b0;
         mem_err      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_ready <= access;
         mem_err   <= access & ~legal;
         mem_busy  <= (state_d != IDLE);
         if (accept) begin
            addr_q  <= mem_addr;
            we_q    <= mem_write_en;
            wdata_q <= mem_data_in;
         end
         // writes leave the read data register holding the last read result
         if (access && !we_q) begin
            mem_data_out <= legal ? rd_data : '0;
         end
      end
   end

   mem_byte_array #(
      .MEM_BYTES (MEM_BYTES)
   ) u_mem_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .addr    (addr_q[AW-1:0]),
      .wr_data (wdata_q),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver predicts each response from a
// byte-array model at acceptance time, a negedge monitor checks every cycle.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int MEM_BYTES = 256;
   localparam int LATENCY   = 4;

   logic             clk          = 1'b0;
   logic             rst_b        = 1'b1;
   logic             mem_req      = 1'b0;
   logic             mem_write_en = 1'b0;
   logic [31:0]      mem_addr     = '0;
   logic [0:3][7:0]  mem_data_in  = '0;
   logic [0:3][7:0]  mem_data_out;
   logic             mem_ready;
   logic             mem_busy;
   logic             mem_err;

   mem_responder #(
      .MEM_BYTES (MEM_BYTES),
      .LATENCY   (LATENCY)
   ) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .mem_ready    (mem_ready),
      .mem_busy     (mem_busy),
      .mem_err      (mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned acc_cyc;
      int unsigned exp_cyc;
      bit          we;
      bit          err;
      logic [31:0] data;
      bit          wrote;
      int unsigned waddr;
      logic [31:0] old;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  model [MEM_BYTES];
   int unsigned cyc       = 0;
   int unsigned next_free = 0;
   int          n_cmp     = 0;
   int          n_bad     = 0;
   logic [31:0] held      = '0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (64'(a) + 64'd3 < 64'(MEM_BYTES));
   endfunction

   // called at a negedge; predicts the response if the next edge accepts
   task automatic drive(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      mem_req      = req;
      mem_write_en = we;
      mem_addr     = a;
      mem_data_in  = d;
      if (req && !rst_b && (cyc + 1 >= next_free)) begin
         e.acc_cyc = cyc + 1;
         e.exp_cyc = cyc + 1 + LATENCY;
         e.we      = we;
         e.err     = !legal(a);
         e.data    = '0;
         e.wrote   = 1'b0;
         e.waddr   = 0;
         e.old     = '0;
         if (!e.err) begin
            for (int i = 0; i < 4; i++) e.old[31-8*i -: 8] = model[a+i];
            if (we) begin
               e.wrote = 1'b1;
               e.waddr = a;
               for (int i = 0; i < 4; i++) model[a+i] = d[31-8*i -: 8];
            end else begin
               e.data = e.old;
            end
         end
         sb.push_back(e);
         next_free = cyc + 1 + LATENCY + 2;
      end
   endtask

   task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] d);
      while (cyc + 1 < next_free) @(negedge clk);
      drive(1'b1, we, a, d);
      @(negedge clk);
      drive(1'b0, 1'($urandom), $urandom, $urandom);
   endtask

   task automatic reset_mid(input int edges);
      exp_t e;
      repeat (edges) @(posedge clk);
      #2;
      rst_b = 1'b1;
      #1;
      check_bit("rst_ready", mem_ready, 1'b0);
      check_bit("rst_busy",  mem_busy,  1'b0);
      check_bit("rst_err",   mem_err,   1'b0);
      check("rst_data", mem_data_out, 32'h0);
      while (sb.size() > 0) begin
         e = sb.pop_back();
         if (e.wrote)
            for (int i = 0; i < 4; i++) model[e.waddr+i] = e.old[31-8*i -: 8];
      end
      held    = '0;
      mem_req = 1'b0;
      @(posedge clk);
      #3;
      rst_b     = 1'b0;
      next_free = cyc + 1;
      @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      bit exp_rdy;
      bit exp_busy;
      if (!rst_b) begin
         exp_rdy  = (sb.size() > 0) && (sb[0].exp_cyc == cyc);
         exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc_cyc);
         check_bit("ready", mem_ready, exp_rdy);
         check_bit("busy",  mem_busy,  exp_busy);
         if (exp_rdy) begin
            check_bit("err", mem_err, sb[0].err);
            if (!sb[0].we) held = sb[0].data;
            check("data_out", mem_data_out, held);
            void'(sb.pop_front());
         end else begin
            check_bit("err_idle", mem_err, 1'b0);
            check("data_held", mem_data_out, held);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] a;
      int          diffs;
      for (int i = 0; i < MEM_BYTES; i++) begin
         model[i] = 8'($urandom);
         dut.u_mem_array.mem[i] = model[i];
      end
      model[16] = 8'h11; model[17] = 8'h22; model[18] = 8'h33; model[19] = 8'h44;
      for (int i = 16; i < 20; i++) dut.u_mem_array.mem[i] = model[i];

      #17;
      rst_b     = 1'b0;
      next_free = cyc + 1;
      @(negedge clk);
      repeat (20) @(negedge clk);

      txn(1'b0, 32'h10, 32'h0);
      repeat (LATENCY + 2) @(negedge clk);
      check("read_0x10", mem_data_out, 32'h11223344);

      reset_mid(1);

      txn(1'b1, 32'h20, 32'hAABBCCDD);
      txn(1'b0, 32'h20, 32'h0);
      repeat (LATENCY + 2) @(negedge clk);
      check("read_0x20", mem_data_out, 32'hAABBCCDD);

      txn(1'b0, 32'h22, 32'h0);
      txn(1'b1, MEM_BYTES, 32'h01020304);
      txn(1'b1, MEM_BYTES - 2, 32'h05060708);
      txn(1'b0, MEM_BYTES - 4, 32'h0);
      txn(1'b1, MEM_BYTES - 4, 32'hDEADBEEF);
      txn(1'b0, 32'hFFFF_FFFC, 32'h0);
      txn(1'b0, MEM_BYTES - 4, 32'h0);

      // held request, inputs changing while busy
      while (cyc + 1 < next_free) @(negedge clk);
      for (int c = 0; c < 4 * (LATENCY + 2); c++) begin
         a = 32'($urandom_range(0, MEM_BYTES / 4 - 1)) << 2;
         drive(1'b1, 1'($urandom), a, $urandom);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);

      txn(1'b1, 32'h40, $urandom);
      reset_mid(2);
      txn(1'b0, 32'h40, 32'h0);

      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, MEM_BYTES / 4 - 1)) << 2;
         else                          a = 32'($urandom_range(0, MEM_BYTES + 8));
         txn(1'($urandom), a, $urandom);
      end

      repeat (LATENCY + 4) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      diffs = 0;
      for (int i = 0; i < MEM_BYTES; i++)
         if (dut.u_mem_array.mem[i] !== model[i]) diffs++;
      check("mem_final_diffs", 32'(diffs), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
